// File: rtl/fpu_req_arbiter_if.sv
// Request, response and FPU-core signals of fpu_req_arbiter.
// The arbiter takes the slave view; requesters plus the core take the master view.
interface fpu_req_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ-1:0]    req_ready_o;
  logic [3*NREQ-1:0]  req_op_i;
  logic [2*NREQ-1:0]  req_rmode_i;
  logic [32*NREQ-1:0] req_opa_i;
  logic [32*NREQ-1:0] req_opb_i;
  logic [NREQ-1:0]    rsp_valid_o;
  logic [31:0]        rsp_result_o;
  logic               rsp_error_o;
  logic               fpu_start_o;
  logic [2:0]         fpu_op_o;
  logic [1:0]         fpu_rmode_o;
  logic [31:0]        fpu_opa_o;
  logic [31:0]        fpu_opb_o;
  logic               fpu_ready_i;
  logic [31:0]        fpu_output_i;
  logic               busy_o;

  modport master (
    output req_valid_i, req_op_i, req_rmode_i, req_opa_i, req_opb_i,
           fpu_ready_i, fpu_output_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_error_o,
           fpu_start_o, fpu_op_o, fpu_rmode_o, fpu_opa_o, fpu_opb_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_rmode_i, req_opa_i, req_opb_i,
           fpu_ready_i, fpu_output_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, rsp_error_o,
           fpu_start_o, fpu_op_o, fpu_rmode_o, fpu_opa_o, fpu_opb_o, busy_o
  );
endinterface

// File: rtl/fpu_req_arbiter.sv
// Round-robin sharing of one non-pipelined FPU core among NREQ requesters.
// States: IDLE arbitrate+capture | ISSUE start pulse | WAIT core or timeout | RESP strobe result.
module fpu_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 63
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  fpu_req_arbiter_if.slave bus
);
  localparam int          GW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;
  localparam logic [7:0]  TO_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [7:0]      cnt_q, cnt_d, cnt_inc;
  logic [2:0]      op_q, op_d;
  logic [1:0]      rmode_q, rmode_d;
  logic [31:0]     opa_q, opa_d;
  logic [31:0]     opb_q, opb_d;
  logic [31:0]     result_q, result_d;
  logic            error_q, error_d;
  logic [NREQ-1:0] ready_v, rsp_v;
  logic            found;
  int              win;

  assign cnt_inc = cnt_q + 8'd1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      last_q   <= GW'(NREQ - 1);
      cnt_q    <= '0;
      op_q     <= '0;
      rmode_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rmode_q  <= rmode_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  // First valid requester after the last one served wins.
  always_comb begin
    found = 1'b0;
    win   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && bus.req_valid_i[(int'(last_q) + i) % NREQ]) begin
        found = 1'b1;
        win   = (int'(last_q) + i) % NREQ;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rmode_d  = rmode_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    error_d  = error_q;
    ready_v  = '0;
    rsp_v    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          ready_v[win] = 1'b1;
          grant_d      = GW'(win);
          op_d         = bus.req_op_i[win*3 +: 3];
          rmode_d      = bus.req_rmode_i[win*2 +: 2];
          opa_d        = bus.req_opa_i[win*32 +: 32];
          opb_d        = bus.req_opb_i[win*32 +: 32];
          if (bus.req_op_i[win*3 +: 3] > 3'd4) begin
            result_d = QNAN;
            error_d  = 1'b1;
            state_d  = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        // Core data takes precedence over a timeout in the same cycle.
        if (bus.fpu_ready_i) begin
          result_d = bus.fpu_output_i;
          error_d  = 1'b0;
          state_d  = S_RESP;
        end else if (cnt_inc == TO_CNT) begin
          result_d = QNAN;
          error_d  = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        rsp_v[grant_q] = 1'b1;
        last_d         = grant_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready_o  = ready_v;
  assign bus.rsp_valid_o  = rsp_v;
  assign bus.rsp_result_o = result_q;
  assign bus.rsp_error_o  = error_q;
  assign bus.fpu_start_o  = (state_q == S_ISSUE);
  assign bus.fpu_op_o     = op_q;
  assign bus.fpu_rmode_o  = rmode_q;
  assign bus.fpu_opa_o    = opa_q;
  assign bus.fpu_opb_o    = opb_q;
  assign bus.busy_o       = (state_q != S_IDLE);
endmodule

// File: doc/fpu_req_arbiter.md
# fpu_req_arbiter

Sequences and shares the single, non-pipelined FPU core between NREQ requesters.
- Round-robin arbitration selects one request at a time.
- The block drives the core's start/operand interface and waits for `fpu_ready_i`.
- It returns the result, or an error, to the granting requester.
- It sits between the agent-facing request ports and the FPU core. Exactly one operation is outstanding at any time.

## Interface
Parameters
- `NREQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 63: maximum WAIT cycles before forced error completion (1..255).

Ports (packed vectors; requester i occupies slice i)
- `clk_i`  in  1  clock, all logic on rising edge.
- `rst_n_i`  in  1  asynchronous active-low reset.
- `req_valid_i`  in  NREQ  request pending, held until accepted.
- `req_ready_o`  out  NREQ  one-hot accept strobe.
- `req_op_i`  in  3*NREQ  op: 0 add, 1 sub, 2 mul, 3 div, 4 sqrt, 5-7 illegal.
- `req_rmode_i`  in  2*NREQ  rounding mode.
- `req_opa_i`, `req_opb_i`  in  32*NREQ  operands.
- `rsp_valid_o`  out  NREQ  one-hot one-cycle completion strobe.
- `rsp_result_o`  out  32  result, valid with any `rsp_valid_o` bit.
- `rsp_error_o`  out  1  timeout or illegal op, valid with `rsp_valid_o`.
- `fpu_start_o`  out  1  one-cycle start pulse to the core.
- `fpu_op_o`  out  3  registered op to the core.
- `fpu_rmode_o`  out  2  registered rounding mode to the core.
- `fpu_opa_o`, `fpu_opb_o`  out  32  registered operands to the core.
- `fpu_ready_i`  in  1  core result valid.
- `fpu_output_i`  in  32  core result.
- `busy_o`  out  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid_i` bit is set, the winner g is the first set bit searching from `last_grant+1` modulo NREQ.
  - `req_ready_o[g]` = 1 combinationally in this cycle only.
  - op, rmode, opa and opb of g are captured into the `fpu_*` registers at the edge.
  - Next state: ISSUE for op ≤ 4. For op ≥ 5, go to RESP with error = 1.
- **ISSUE**: `fpu_start_o` = 1 for exactly this cycle. The WAIT counter is cleared. Next state: WAIT.
- **WAIT**
  - Counter increments each cycle.
  - On `fpu_ready_i` = 1: capture `fpu_output_i`, error = 0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT: result = 0x7FC00000, error = 1, go to RESP.
  - Ready and timeout in the same cycle: ready wins.
- **RESP**
  - `rsp_valid_o[g]` = 1, `rsp_result_o`/`rsp_error_o` driven from registers.
  - `last_grant` ← g. Next state: IDLE.
  - Illegal-op result is 0x7FC00000.
- Result, error and `fpu_*` registers hold their value between operations. Only the strobes are one-cycle.
- `fpu_ready_i` is ignored outside WAIT.
- `req_valid_i` is not sampled outside IDLE. A requester deasserting valid before accept is legal; it is simply not granted.

## Timing
- Reset values: state IDLE, `last_grant` = NREQ-1 (requester 0 has first priority), all outputs 0, counter 0.
- Reset asserted mid-operation: immediate return to IDLE. No response is delivered and `fpu_start_o` drops asynchronously. Requesters must reissue.
- Latency, with accept at cycle 0 and the core's ready at cycle r ≥ 2 (WAIT begins cycle 2):
  - `fpu_start_o` at cycle 1.
  - `rsp_valid_o` at cycle r+1.
- Illegal op: accept at cycle 0, response at cycle 1.
- Timeout: response at cycle TIMEOUT+2 after accept.
- Back-to-back throughput: the next accept occurs at the earliest one cycle after RESP, so the minimum period is 4 cycles.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ-1 operations.

## Test plan
- Single add, req 0: opa 0x3F800000, opb 0x40000000, core ready 3 cycles after start with 0x40400000 -> `req_ready_o` = 0001 at cycle 0; start at cycle 1; `rsp_valid_o` = 0001, result 0x40400000, error 0 at cycle 5.
- All 4 requesters valid continuously, core ready 1 cycle after start -> grants 0,1,2,3,0 in order; each period 4 cycles; exactly one `rsp_valid_o` bit per response.
- Core never asserts ready, TIMEOUT = 63 -> response at cycle 65 after accept, result 0x7FC00000, error 1; next request proceeds normally.
- Req 2 with op 6 -> accept then `rsp_valid_o` = 0100 next cycle, error 1; `fpu_start_o` never pulses.
- Reset pulse during WAIT -> outputs 0 immediately, no `rsp_valid_o`. After release with req 1 only valid, req 1 is accepted and the `fpu_*` registers reload.
- Spurious `fpu_ready_i` during IDLE/ISSUE and ready/timeout coincident at counter = TIMEOUT -> spurious ignored; coincident case returns core data with error 0.
